lsu_mem_master: RTL and testbench

Load/store unit that drives a word-organised data memory as the requesting side of a request/acknowledge port. The execute stage hands it lw/lb/sw/sb operations. It returns load data or store completion to the pipeline. It performs the byte-lane work itself: sign-extended byte extraction for lb, and read-modify-write for sb, so the memory only ever sees full-word reads and writes.

---
 rtl/lsu_mem_master.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit acting as the requester on a word-wide
// request/acknowledge memory port. Handles lw, lb, sw and sb. lb gets
// sign-extended lane extraction. sb gets a read-modify-write, so the memory
// only ever sees full-word accesses.
// Optional feature macro: LSU_DISPLAY_EN (prints every completed write).
module lsu_mem_master #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_LB = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_SW = 2'b11;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [7:0]  wbyte_q;
  logic [31:0] pc_q;

  logic [7:0]  lane_byte;
  logic [31:0] merged_word;
  logic        misaligned;

  // A word access to a non-word-aligned address is rejected without touching memory.
  assign misaligned = ((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00);

  // Select the addressed byte lane of the read word and build the sb merge word.
  always_comb begin
    lane_byte   = mem_rdata[7:0];
    merged_word = mem_rdata;
    case (addr_q[1:0])
      2'd0: begin
        lane_byte         = mem_rdata[7:0];
        merged_word[7:0]  = wbyte_q;
      end
      2'd1: begin
        lane_byte         = mem_rdata[15:8];
        merged_word[15:8] = wbyte_q;
      end
      2'd2: begin
        lane_byte          = mem_rdata[23:16];
        merged_word[23:16] = wbyte_q;
      end
      default: begin
        lane_byte          = mem_rdata[31:24];
        merged_word[31:24] = wbyte_q;
      end
    endcase
  end

  // Main control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      op_q       <= OP_LW;
      addr_q     <= 32'h0;
      wbyte_q    <= 8'h0;
      pc_q       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            wbyte_q   <= req_wdata[7:0];
            pc_q      <= req_pc;
            req_ready <= 1'b0;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_op == OP_SW) begin
              state     <= WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[MEM_AW+1:2];
              mem_wdata <= req_wdata;
            end else begin
              state    <= RD;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= req_addr[MEM_AW+1:2];
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            case (op_q)
              OP_LW: begin
                state      <= RESP;
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                resp_rdata <= mem_rdata;
              end
              OP_LB: begin
                state      <= RESP;
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                resp_rdata <= {{24{lane_byte[7]}}, lane_byte};
              end
              OP_SB: begin
                state     <= WR;
                mem_we    <= 1'b1;
                mem_wdata <= merged_word;
              end
              default: begin
                state      <= RESP;
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                resp_rdata <= 32'h0;
              end
            endcase
          end
        end
        WR: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_DISPLAY_EN
  // Trace each completed write with its pc and word-aligned byte address.
  always @(posedge clk) begin
    if (reset && (state == WR) && mem_ack)
      $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, mem_wdata);
  end
`else
  logic unused_bits;
  assign unused_bits = ^{pc_q, addr_q[31:2]};
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed test of lsu_mem_master against a small
// word memory model with a configurable number of wait states.
module tb_lsu_mem_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int compared;
  int mismatched;

  logic [31:0] mem [0:1023];
  int          wait_req;
  int          wait_used;
  int          write_cnt;
  logic [9:0]  last_waddr;
  logic [31:0] last_wdata;

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          memreq_cycles;
  logic        ready_bad;
  logic        unstable;
  logic        flag;
  int          wc_before;

  lsu_mem_master #(.MEM_AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_req stalled cycles, data presented on the falling edge.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_used < wait_req) begin
        mem_ack   = 1'b0;
        wait_used = wait_used + 1;
      end else begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'h0 : mem[mem_addr];
      end
    end else begin
      mem_ack   = 1'b0;
      wait_used = 0;
    end
  end

  // Memory model: commit a write on the edge that samples the ack.
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) begin
      mem[mem_addr] = mem_wdata;
      write_cnt     = write_cnt + 1;
      last_waddr    = mem_addr;
      last_wdata    = mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Issue one operation and wait for its response; latency counts falling edges after accept.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic        got;
    logic        first;
    logic [9:0]  a0;
    logic        we0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = 32'h0000_1000 + addr;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0; first = 1'b1;
    memreq_cycles = 0; ready_bad = 1'b0; unstable = 1'b0;
    rdata = 32'hx; err = 1'bx;
    a0 = '0; we0 = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat = lat + 1;
      if (mem_req) begin
        memreq_cycles = memreq_cycles + 1;
        if (first) begin
          a0 = mem_addr; we0 = mem_we; first = 1'b0;
        end else if (mem_addr !== a0 || mem_we !== we0) begin
          unstable = 1'b1;
        end
      end
      if (resp_valid) begin
        got = 1'b1; rdata = resp_rdata; err = resp_err;
      end else if (req_ready) begin
        ready_bad = 1'b1;
      end
    end
    if (!got) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    wait_req = 0; write_cnt = 0;
    last_waddr = '0; last_wdata = '0;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'd0);
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    $display("[TB] reset released");

    // Store then load
    wc_before = write_cnt;
    applyStimulus(2'b11, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_latency", lat, 32'd2);
    checkOutput("sw_err", {31'h0, err}, 32'd0);
    checkOutput("sw_rdata", rdata, 32'h0);
    checkOutput("sw_writes", write_cnt - wc_before, 32'd1);
    checkOutput("sw_waddr", {22'h0, last_waddr}, 32'h4);
    checkOutput("sw_wdata", last_wdata, 32'hDEADBEEF);
    checkOutput("sw_ready_low", {31'h0, ready_bad}, 32'd0);
    applyStimulus(2'b00, 32'h10, 32'h0);
    checkOutput("lw_latency", lat, 32'd2);
    checkOutput("lw_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("resp_one_cycle", {31'h0, resp_valid}, 32'd0);
    checkOutput("rdata_cleared", resp_rdata, 32'h0);

    // lb sign extension on every lane
    applyStimulus(2'b11, 32'h20, 32'h80FF7F01);
    applyStimulus(2'b01, 32'h20, 32'h0);
    checkOutput("lb0_rdata", rdata, 32'h00000001);
    checkOutput("lb0_latency", lat, 32'd2);
    applyStimulus(2'b01, 32'h21, 32'h0);
    checkOutput("lb1_rdata", rdata, 32'h0000007F);
    applyStimulus(2'b01, 32'h22, 32'h0);
    checkOutput("lb2_rdata", rdata, 32'hFFFFFFFF);
    applyStimulus(2'b01, 32'h23, 32'h0);
    checkOutput("lb3_rdata", rdata, 32'hFFFFFF80);
    checkOutput("lb3_err", {31'h0, err}, 32'd0);

    // sb read-modify-write
    applyStimulus(2'b11, 32'h0C, 32'h11223344);
    wc_before = write_cnt;
    applyStimulus(2'b10, 32'h0E, 32'hFFFFFFAB);
    checkOutput("sb_latency", lat, 32'd3);
    checkOutput("sb_writes", write_cnt - wc_before, 32'd1);
    checkOutput("sb_waddr", {22'h0, last_waddr}, 32'h3);
    checkOutput("sb_wdata", last_wdata, 32'h11AB3344);
    checkOutput("sb_rdata", rdata, 32'h0);
    applyStimulus(2'b00, 32'h0C, 32'h0);
    checkOutput("sb_readback", rdata, 32'h11AB3344);

    // Misaligned word accesses
    wc_before = write_cnt;
    applyStimulus(2'b11, 32'h13, 32'h12345678);
    checkOutput("mis_sw_latency", lat, 32'd1);
    checkOutput("mis_sw_err", {31'h0, err}, 32'd1);
    checkOutput("mis_sw_memreq", memreq_cycles, 32'd0);
    checkOutput("mis_sw_writes", write_cnt - wc_before, 32'd0);
    applyStimulus(2'b00, 32'h02, 32'h0);
    checkOutput("mis_lw_latency", lat, 32'd1);
    checkOutput("mis_lw_err", {31'h0, err}, 32'd1);
    checkOutput("mis_lw_rdata", rdata, 32'h0);
    checkOutput("mis_lw_memreq", memreq_cycles, 32'd0);
    @(negedge clk);
    checkOutput("err_cleared", {31'h0, resp_err}, 32'd0);

    // Memory wait states
    wait_req = 3;
    applyStimulus(2'b00, 32'h10, 32'h0);
    wait_req = 0;
    checkOutput("wait_latency", lat, 32'd5);
    checkOutput("wait_rdata", rdata, 32'hDEADBEEF);
    checkOutput("wait_memreq_cycles", memreq_cycles, 32'd4);
    checkOutput("wait_stable", {31'h0, unstable}, 32'd0);
    checkOutput("wait_ready_low", {31'h0, ready_bad}, 32'd0);

    // Reset between the sb read ack and the write ack
    wc_before = write_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h0E; req_wdata = 32'h55; req_pc = 32'h2000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 wait_req = 5;
    @(negedge clk);
    checkOutput("mid_sb_in_wr", {30'h0, mem_req, mem_we}, 32'h3);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_sb_memreq_async", {31'h0, mem_req}, 32'd0);
    checkOutput("mid_sb_ready", {31'h0, req_ready}, 32'd1);
    flag = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) flag = 1'b1;
    end
    wait_req = 0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || !req_ready) flag = 1'b1;
    end
    checkOutput("mid_sb_no_resp", {31'h0, flag}, 32'd0);
    checkOutput("mid_sb_writes", write_cnt - wc_before, 32'd0);
    applyStimulus(2'b00, 32'h0C, 32'h0);
    checkOutput("mid_sb_mem_intact", rdata, 32'h11AB3344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
